// File: rtl/bin_to_bcd8_if.sv
// Request/result bundle for the 8-digit binary-to-BCD converter.
// start is a request that is accepted only on a rising edge where busy=0; done is a one-cycle result strobe.
interface bin_to_bcd8_if #(parameter int WIDTH = 27);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0;

    modport master (
        output start, bin,
        input  busy, done, ovf, dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0
    );
endinterface

// File: rtl/bin_to_bcd8.sv
// Sequential double-dabble converter: WIDTH-bit unsigned binary to eight registered BCD digits.
// Values above 99,999,999 saturate the display to all nines and raise ovf.
module bin_to_bcd8 #(
    parameter int WIDTH = 27
) (
    input  logic              clk,
    input  logic              rst,
    bin_to_bcd8_if.slave      bus,
    output logic [1:0]        dbg_state
);

    localparam int          CW        = $clog2(WIDTH + 1);
    localparam logic [31:0] OVF_LIMIT = 32'd99_999_999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] binreg_q, binreg_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [31:0]      dig_q, dig_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [31:0]      adj;

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 8; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        binreg_d   = binreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        dig_d      = dig_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    binreg_d   = bus.bin;
                    scratch_d  = '0;
                    cnt_d      = CW'(WIDTH);
                    ovf_pend_d = (32'(bus.bin) > OVF_LIMIT);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = (adj << 1) | {31'd0, binreg_q[WIDTH-1]};
                binreg_d  = binreg_q << 1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dig_d   = ovf_pend_q ? 32'h9999_9999 : scratch_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            binreg_q   <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            dig_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            binreg_q   <= binreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            dig_q      <= dig_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.dig7  = dig_q[31:28];
    assign bus.dig6  = dig_q[27:24];
    assign bus.dig5  = dig_q[23:20];
    assign bus.dig4  = dig_q[19:16];
    assign bus.dig3  = dig_q[15:12];
    assign bus.dig2  = dig_q[11:8];
    assign bus.dig1  = dig_q[7:4];
    assign bus.dig0  = dig_q[3:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd8.sv
// Directed bench for bin_to_bcd8: vector table, busy/start corner cases, async reset abort and a streaming run.
module tb_bin_to_bcd8;

    localparam int W = 27;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    bin_to_bcd8_if #(.WIDTH(W)) bus ();

    bin_to_bcd8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [W-1:0] b;
        logic [31:0]  d;
        logic         o;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dig_word();
        return {bus.dig7, bus.dig6, bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.dig0};
    endfunction

    // Reference conversion by decimal division.
    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ---------------- driver tasks (entered and left on a negedge) ----------------
    task automatic run_vec(input string name, input logic [W-1:0] b, input logic [31:0] exp_d,
                           input logic exp_o, input int rep);
        int c;
        int nb;
        c = 0;
        while (bus.busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        bus.bin   = b;
        bus.start = 1'b1;
        c  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            c++;
            if (bus.busy) nb++;
            if (c == 1) begin
                bus.start = 1'b0;
                bus.bin   = W'($urandom);
            end
            if (rep > 0 && c == rep) begin
                bus.start = 1'b1;
                bus.bin   = W'(777);
            end
            if (rep > 0 && c == rep + 1) bus.start = 1'b0;
        end while (!bus.done && c < 100);
        chk({name, "_latency"}, c, W + 2);
        chk({name, "_busy_cycles"}, nb, W + 1);
        chk({name, "_digits"}, dig_word(), exp_d);
        chk({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({name, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
        chk({name, "_digits_held"}, dig_word(), exp_d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int nd;
        int nres;
        int last;

        tbl[0]  = '{b: W'(0),           d: 32'h0000_0000, o: 1'b0};
        tbl[1]  = '{b: W'(12_345_678),  d: 32'h1234_5678, o: 1'b0};
        tbl[2]  = '{b: W'(99_999_999),  d: 32'h9999_9999, o: 1'b0};
        tbl[3]  = '{b: W'(134_217_727), d: 32'h9999_9999, o: 1'b1};
        tbl[4]  = '{b: W'(5),           d: 32'h0000_0005, o: 1'b0};
        tbl[5]  = '{b: W'(100_000_000), d: 32'h9999_9999, o: 1'b1};
        tbl[6]  = '{b: W'(99_999_998),  d: 32'h9999_9998, o: 1'b0};
        tbl[7]  = '{b: W'(9),           d: 32'h0000_0009, o: 1'b0};
        tbl[8]  = '{b: W'(10),          d: 32'h0000_0010, o: 1'b0};
        tbl[9]  = '{b: W'(59),          d: 32'h0000_0059, o: 1'b0};
        tbl[10] = '{b: W'(65_535),      d: 32'h0006_5535, o: 1'b0};
        tbl[11] = '{b: W'(1_234_567),   d: 32'h0123_4567, o: 1'b0};
        tbl[12] = '{b: W'(67_108_863),  d: 32'h6710_8863, o: 1'b0};
        tbl[13] = '{b: W'(80_808_080),  d: 32'h8080_8080, o: 1'b0};
        tbl[14] = '{b: W'(1),           d: 32'h0000_0001, o: 1'b0};
        tbl[15] = '{b: W'(10_000_000),  d: 32'h1000_0000, o: 1'b0};

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clk);
        chk("reset_digits", dig_word(), 32'd0);
        chk("reset_flags", {29'd0, bus.busy, bus.done, bus.ovf}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].b, tbl[i].d, tbl[i].o, 0);
        end

        // start re-pulsed while busy must be ignored
        run_vec("repulse", W'(42), 32'h0000_0042, 1'b0, 5);
        c = 0;
        nd = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.busy) c++;
        end
        chk("repulse_no_second_done", nd, 0);
        chk("repulse_no_queued_busy", c, 0);

        // async reset in the middle of a conversion
        run_vec("pre_abort", W'(12_345_678), 32'h1234_5678, 1'b0, 0);
        bus.bin   = W'(55);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_digits_zero", dig_word(), 32'd0);
        chk("abort_flags_zero", {29'd0, bus.busy, bus.done, bus.ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        nd = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        chk("abort_no_done", nd, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_vec("after_reset", W'(9), 32'h0000_0009, 1'b0, 0);

        // start held high: each done cycle must also accept the next value
        bus.bin   = W'(0);
        exp_q.push_back(to_bcd(0));
        bus.start = 1'b1;
        nres = 0;
        last = 0;
        c    = 0;
        while (nres < 1001 && c < 40_000) begin
            @(negedge clk);
            c++;
            if (bus.done) begin
                chk($sformatf("stream_dig%0d", nres), dig_word(), exp_q.pop_front());
                if (nres > 0) chk("stream_period", c - last, W + 2);
                last = c;
                nres++;
                if (nres < 1001) begin
                    bus.bin = W'(nres);
                    exp_q.push_back(to_bcd(nres));
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        chk("stream_count", nres, 1001);
        @(negedge clk);
        chk("stream_idle_end", {31'd0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
